// File: rtl/addsub_pkg.sv
// Shared types and constants for the adder-subtractor requester and its watchdog.
package addsub_pkg;

   localparam int DEFAULT_N = 8;

   localparam logic OP_ADD = 1'b0;
   localparam logic OP_SUB = 1'b1;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LAUNCH = 2'd1,
      WAIT   = 2'd2,
      HOLD   = 2'd3
   } state_t;

   // Debug view: FSM state plus the core's busy flag, which is status only.
   typedef struct packed {
      state_t state;
      logic   core_calc;
   } dbg_t;

endpackage

// File: rtl/addsub_requester_if.sv
// Request, response and core-side signals of the requester, grouped with modports.
interface addsub_requester_if
   import addsub_pkg::*;
#(
   parameter int N     = DEFAULT_N,
   parameter int CNT_W = 16
) ();

   // Handshakes: a transfer happens on a rising clock edge where valid and ready are both 1.
   logic             req_valid;
   logic             req_ready;
   logic [N-1:0]     req_a;
   logic [N-1:0]     req_b;
   logic             req_op;
   logic             rsp_valid;
   logic             rsp_ready;
   logic [N-1:0]     rsp_sum;
   logic             rsp_cout;
   logic             rsp_err;
   logic [N-1:0]     core_a;
   logic [N-1:0]     core_b;
   logic             core_addsub;
   logic             core_start;
   logic [N-1:0]     core_sum;
   logic             core_cout;
   logic             core_done;
   logic             core_calculating;
   logic             busy;
   logic [CNT_W-1:0] ops_count;
   dbg_t             dbg;

   modport slave (
      input  req_valid, req_a, req_b, req_op, rsp_ready,
      input  core_sum, core_cout, core_done, core_calculating,
      output req_ready, rsp_valid, rsp_sum, rsp_cout, rsp_err,
      output core_a, core_b, core_addsub, core_start, busy, ops_count, dbg
   );

   modport master (
      output req_valid, req_a, req_b, req_op, rsp_ready,
      output core_sum, core_cout, core_done, core_calculating,
      input  req_ready, rsp_valid, rsp_sum, rsp_cout, rsp_err,
      input  core_a, core_b, core_addsub, core_start, busy, ops_count, dbg
   );

endinterface

// File: rtl/addsub_watchdog.sv
// Cycle counter that flags expiry on the cycle its count reaches TIMEOUT-1 while enabled.
module addsub_watchdog #(
   parameter int TIMEOUT = 32
) (
   input  logic clk,
   input  logic rst,
   input  logic i_clear,
   input  logic i_enable,
   output logic o_expired
);

   localparam int W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   logic [W-1:0] r_count;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_count <= '0;
      end else if (i_clear) begin
         r_count <= '0;
      end else if (i_enable) begin
         r_count <= r_count + 1'b1;
      end
   end

   assign o_expired = i_enable && (r_count == W'(TIMEOUT - 1));

endmodule

// File: rtl/addsub_requester.sv
// Launches queued add/sub requests on the multi-cycle core and returns the results,
// with a watchdog that turns a missing done into an error response.
module addsub_requester
   import addsub_pkg::*;
#(
   parameter int N       = DEFAULT_N,
   parameter int TIMEOUT = 32,
   parameter int CNT_W   = 16
) (
   input logic               clk,
   input logic               rst,
   addsub_requester_if.slave bus
);

   state_t           r_state;
   logic [N-1:0]     r_core_a;
   logic [N-1:0]     r_core_b;
   logic             r_core_addsub;
   logic             r_core_start;
   logic             r_rsp_valid;
   logic [N-1:0]     r_rsp_sum;
   logic             r_rsp_cout;
   logic             r_rsp_err;
   logic             r_busy;
   logic [CNT_W-1:0] r_ops_count;

   logic w_req_hs;
   logic w_wd_expired;

   // A new request is taken when idle, or while the pending response is being consumed.
   assign bus.req_ready = (r_state == IDLE) || ((r_state == HOLD) && bus.rsp_ready);
   assign w_req_hs      = bus.req_valid && bus.req_ready;

   addsub_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
      .clk       (clk),
      .rst       (rst),
      .i_clear   (r_state == LAUNCH),
      .i_enable  (r_state == WAIT),
      .o_expired (w_wd_expired)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state       <= IDLE;
         r_core_a      <= '0;
         r_core_b      <= '0;
         r_core_addsub <= OP_ADD;
         r_core_start  <= 1'b0;
         r_rsp_valid   <= 1'b0;
         r_rsp_sum     <= '0;
         r_rsp_cout    <= 1'b0;
         r_rsp_err     <= 1'b0;
         r_busy        <= 1'b0;
         r_ops_count   <= '0;
      end else begin
         r_core_start <= 1'b0;
         case (r_state)
            IDLE: begin
               if (w_req_hs) begin
                  r_core_a      <= bus.req_a;
                  r_core_b      <= bus.req_b;
                  r_core_addsub <= bus.req_op;
                  r_core_start  <= 1'b1;
                  r_busy        <= 1'b1;
                  r_state       <= LAUNCH;
               end
            end
            LAUNCH: r_state <= WAIT;
            WAIT: begin
               // A done on the expiry cycle still counts as a good result.
               if (bus.core_done) begin
                  r_rsp_sum   <= bus.core_sum;
                  r_rsp_cout  <= bus.core_cout;
                  r_rsp_err   <= 1'b0;
                  r_rsp_valid <= 1'b1;
                  r_busy      <= 1'b0;
                  r_ops_count <= r_ops_count + 1'b1;
                  r_state     <= HOLD;
               end else if (w_wd_expired) begin
                  r_rsp_sum   <= '0;
                  r_rsp_cout  <= 1'b0;
                  r_rsp_err   <= 1'b1;
                  r_rsp_valid <= 1'b1;
                  r_busy      <= 1'b0;
                  r_ops_count <= r_ops_count + 1'b1;
                  r_state     <= HOLD;
               end
            end
            HOLD: begin
               if (bus.rsp_ready) begin
                  r_rsp_valid <= 1'b0;
                  if (w_req_hs) begin
                     r_core_a      <= bus.req_a;
                     r_core_b      <= bus.req_b;
                     r_core_addsub <= bus.req_op;
                     r_core_start  <= 1'b1;
                     r_busy        <= 1'b1;
                     r_state       <= LAUNCH;
                  end else begin
                     r_state <= IDLE;
                  end
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign bus.core_a      = r_core_a;
   assign bus.core_b      = r_core_b;
   assign bus.core_addsub = r_core_addsub;
   assign bus.core_start  = r_core_start;
   assign bus.rsp_valid   = r_rsp_valid;
   assign bus.rsp_sum     = r_rsp_sum;
   assign bus.rsp_cout    = r_rsp_cout;
   assign bus.rsp_err     = r_rsp_err;
   assign bus.busy        = r_busy;
   assign bus.ops_count   = r_ops_count;
   assign bus.dbg         = '{state: r_state, core_calc: bus.core_calculating};

endmodule

// File: tb/tb_addsub_requester.sv
// Bench for addsub_requester: a behavioural core, directed scenarios with literal
// expectations, then randomized traffic checked every cycle against a transaction model.
module tb_addsub_requester;
   import addsub_pkg::*;

   localparam int N       = 8;
   localparam int TIMEOUT = 32;
   localparam int CNT_W   = 16;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   addsub_requester_if #(.N(N), .CNT_W(CNT_W)) bus ();

   addsub_requester #(.N(N), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
      end
   endtask

   // ---------------- response-ready source ----------------
   logic rdy_drv = 1'b1;
   logic rdy_rand = 1'b1;
   bit   rdy_random = 1'b0;
   assign bus.rsp_ready = rdy_random ? rdy_rand : rdy_drv;

   always @(posedge clk) begin
      #1;
      if (rdy_random) rdy_rand = ($urandom_range(0, 3) != 0);
   end

   // ---------------- behavioural core ----------------
   int         dly_q[$];
   int         core_d;
   int         done_cyc = -1;
   logic [N:0] core_res;
   bit         inj_done = 1'b0;

   always @(negedge clk) begin
      if (!rst) begin
         done_cyc = -1;
         dly_q.delete();
      end else if (bus.core_start) begin
         core_d   = (dly_q.size() != 0) ? dly_q.pop_front() : 0;
         core_res = bus.core_addsub ? ({1'b0, bus.core_a} - {1'b0, bus.core_b})
                                    : ({1'b0, bus.core_a} + {1'b0, bus.core_b});
         done_cyc = (core_d > 0) ? cyc + core_d : -1;
      end
   end

   always @(posedge clk) begin
      #1;
      if (done_cyc >= 0 && cyc == done_cyc) begin
         bus.core_done = 1'b1;
         bus.core_sum  = core_res[N-1:0];
         bus.core_cout = core_res[N];
      end else begin
         bus.core_done = inj_done;
         bus.core_sum  = N'($urandom);
         bus.core_cout = 1'($urandom);
      end
      bus.core_calculating = (done_cyc >= 0) && (cyc < done_cyc);
   end

   // ---------------- transaction model + per-cycle compare ----------------
   logic [N:0]       exp_q[$];
   bit               m_inflight = 1'b0;
   bit               m_hold = 1'b0;
   int               m_age = 0;
   logic [N-1:0]     m_a, m_b;
   logic             m_op;
   logic [N+1:0]     m_rsp;
   logic [CNT_W-1:0] m_ops = '0;
   int               start_cnt = 0;

   task m_accept();
      m_inflight = 1'b1;
      m_age      = 1;
      m_a        = bus.req_a;
      m_b        = bus.req_b;
      m_op       = bus.req_op;
      exp_q.push_back(bus.req_op ? ({1'b0, bus.req_a} - {1'b0, bus.req_b})
                                 : ({1'b0, bus.req_a} + {1'b0, bus.req_b}));
   endtask

   always @(negedge clk) begin
      if (!rst) begin
         m_inflight = 1'b0;
         m_hold     = 1'b0;
         m_ops      = '0;
         exp_q.delete();
      end
      if (bus.core_start) start_cnt++;
      chk("req_ready", bus.req_ready, (!m_inflight && !m_hold) || (m_hold && bus.rsp_ready));
      chk("busy", bus.busy, m_inflight);
      chk("core_start", bus.core_start, m_inflight && (m_age == 1));
      if (m_inflight) begin
         chk("core_a", bus.core_a, m_a);
         chk("core_b", bus.core_b, m_b);
         chk("core_addsub", bus.core_addsub, m_op);
      end
      chk("rsp_valid", bus.rsp_valid, m_hold);
      if (m_hold) chk("rsp_payload", {bus.rsp_err, bus.rsp_cout, bus.rsp_sum}, m_rsp);
      chk("ops_count", bus.ops_count, m_ops);
      chk("dbg_core_calc", bus.dbg.core_calc, bus.core_calculating);
      if (rst) begin
         if (m_hold) begin
            if (bus.rsp_ready) begin
               m_hold = 1'b0;
               if (bus.req_valid) m_accept();
            end
         end else if (m_inflight) begin
            if (m_age >= 2 && bus.core_done) begin
               m_rsp      = {1'b0, exp_q.pop_front()};
               m_hold     = 1'b1;
               m_inflight = 1'b0;
               m_ops++;
            end else if (m_age == TIMEOUT + 1) begin
               void'(exp_q.pop_front());
               m_rsp      = {1'b1, {(N+1){1'b0}}};
               m_hold     = 1'b1;
               m_inflight = 1'b0;
               m_ops++;
            end else begin
               m_age++;
            end
         end else if (bus.req_valid) begin
            m_accept();
         end
      end
   end

   // ---------------- driver tasks ----------------
   int hs_cyc = 0;

   task automatic send(input logic [N-1:0] a, input logic [N-1:0] b, input logic op, input int d);
      bit got = 1'b0;
      bus.req_a     = a;
      bus.req_b     = b;
      bus.req_op    = op;
      bus.req_valid = 1'b1;
      for (int i = 0; i < 200 && !got; i++) begin
         @(negedge clk);
         if (bus.req_ready) begin
            got = 1'b1;
            dly_q.push_back(d);
         end
         @(posedge clk);
         #1;
      end
      bus.req_valid = 1'b0;
      hs_cyc        = cyc;
      chk("req_accepted", got, 1'b1);
   endtask

   task automatic wait_rsp(input string tag, input logic [N-1:0] es, input logic ec,
                           input logic ee, input int elat);
      bit seen = 1'b0;
      for (int i = 0; i < 100 && !seen; i++) begin
         @(negedge clk);
         seen = bus.rsp_valid;
      end
      chk({tag, "_seen"}, seen, 1'b1);
      chk({tag, "_latency"}, cyc - hs_cyc, elat);
      chk({tag, "_sum"}, bus.rsp_sum, es);
      chk({tag, "_cout"}, bus.rsp_cout, ec);
      chk({tag, "_err"}, bus.rsp_err, ee);
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_rsp_valid"}, bus.rsp_valid, 1'b0);
      chk({tag, "_rsp_sum"}, bus.rsp_sum, 0);
      chk({tag, "_rsp_cout"}, bus.rsp_cout, 1'b0);
      chk({tag, "_rsp_err"}, bus.rsp_err, 1'b0);
      chk({tag, "_core_start"}, bus.core_start, 1'b0);
      chk({tag, "_core_a"}, bus.core_a, 0);
      chk({tag, "_core_b"}, bus.core_b, 0);
      chk({tag, "_core_addsub"}, bus.core_addsub, 1'b0);
      chk({tag, "_busy"}, bus.busy, 1'b0);
      chk({tag, "_ops_count"}, bus.ops_count, 0);
      chk({tag, "_req_ready"}, bus.req_ready, 1'b1);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int starts0;
      bus.req_valid = 1'b0;
      bus.req_a     = '0;
      bus.req_b     = '0;
      bus.req_op    = OP_ADD;
      rst = 1'b1;
      #1 rst = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b1;

      // reset state, then a stray done while idle
      @(negedge clk);
      chk_reset_outputs("reset");
      @(posedge clk); #1;
      inj_done = 1'b1;
      repeat (2) @(posedge clk);
      #1 inj_done = 1'b0;
      repeat (2) @(negedge clk);
      chk("idle_done_ops", bus.ops_count, 0);
      chk("idle_done_rsp_valid", bus.rsp_valid, 1'b0);
      @(posedge clk); #1;

      // 42 + 15 with D = 8
      starts0 = start_cnt;
      send(8'd42, 8'd15, OP_ADD, 8);
      wait_rsp("add", 8'h39, 1'b0, 1'b0, 9);
      chk("add_start_pulses", start_cnt - starts0, 1);
      chk("add_core_a", bus.core_a, 8'h2A);
      chk("add_core_b", bus.core_b, 8'h0F);
      chk("add_ops", bus.ops_count, 1);
      @(posedge clk); #1;

      // 255 + 1 held 5 cycles, then 2 - 4 back-to-back
      rdy_drv = 1'b0;
      send(8'd255, 8'd1, OP_ADD, 3);
      bus.req_a     = 8'd2;
      bus.req_b     = 8'd4;
      bus.req_op    = OP_SUB;
      bus.req_valid = 1'b1;
      wait_rsp("carry", 8'h00, 1'b1, 1'b0, 4);
      for (int i = 0; i < 5; i++) begin
         if (i > 0) @(negedge clk);
         chk("carry_hold_valid", bus.rsp_valid, 1'b1);
         chk("carry_hold_sum", bus.rsp_sum, 8'h00);
         chk("carry_hold_cout", bus.rsp_cout, 1'b1);
         chk("carry_hold_req_ready", bus.req_ready, 1'b0);
      end
      @(posedge clk); #1;
      rdy_drv = 1'b1;
      @(negedge clk);
      chk("b2b_req_ready", bus.req_ready, 1'b1);
      dly_q.push_back(4);
      @(posedge clk); #1;
      bus.req_valid = 1'b0;
      hs_cyc = cyc;
      @(negedge clk);
      chk("b2b_launch", bus.core_start, 1'b1);
      chk("b2b_rsp_dropped", bus.rsp_valid, 1'b0);
      wait_rsp("b2b", 8'hFE, 1'b1, 1'b0, 5);
      chk("b2b_ops", bus.ops_count, 3);
      @(posedge clk); #1;

      // watchdog timeout, then a late done
      send(8'h10, 8'h20, OP_ADD, 0);
      wait_rsp("timeout", 8'h00, 1'b0, 1'b1, TIMEOUT + 1);
      @(posedge clk); #1;
      inj_done = 1'b1;
      @(posedge clk); #1;
      inj_done = 1'b0;
      repeat (3) @(negedge clk);
      chk("timeout_ops", bus.ops_count, 4);
      chk("late_done_rsp_valid", bus.rsp_valid, 1'b0);
      @(posedge clk); #1;

      // done on the expiry cycle
      send(8'h50, 8'h05, OP_ADD, TIMEOUT);
      wait_rsp("collide", 8'h55, 1'b0, 1'b0, TIMEOUT + 1);
      @(posedge clk); #1;

      // reset in the middle of WAIT
      send(8'd88, 8'd22, OP_SUB, 8);
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      #1 chk_reset_outputs("midreset");
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
      repeat (2) @(posedge clk);
      #1 inj_done = 1'b1;
      @(posedge clk);
      #1 inj_done = 1'b0;
      repeat (3) @(negedge clk);
      chk("post_reset_ops", bus.ops_count, 0);
      chk("post_reset_rsp_valid", bus.rsp_valid, 1'b0);
      chk("post_reset_busy", bus.busy, 1'b0);
      @(posedge clk); #1;
      send(8'd17, 8'd17, OP_SUB, 5);
      wait_rsp("zero", 8'h00, 1'b0, 1'b0, 6);
      chk("zero_ops", bus.ops_count, 1);
      @(posedge clk); #1;

      // randomized traffic with random response back-pressure
      rdy_random = 1'b1;
      for (int n = 0; n < 150; n++) begin
         int d;
         int gap;
         gap = $urandom_range(0, 2);
         d   = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, TIMEOUT + 4));
         repeat (gap) begin
            @(posedge clk);
            #1;
         end
         send(N'($urandom), N'($urandom), 1'($urandom_range(0, 1)), d);
      end
      begin
         bit idle = 1'b0;
         for (int i = 0; i < 300 && !idle; i++) begin
            @(negedge clk);
            idle = !m_inflight && !m_hold;
         end
         chk("drain_idle", idle, 1'b1);
      end
      chk("drain_queue_empty", exp_q.size(), 0);
      chk("final_ops", bus.ops_count, 151);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
